// File: rtl/char_ram_arbiter_pkg.sv
// Shared widths, grant/read-FSM encodings and the write-buffer entry type
// for the character RAM arbiter.
package char_ram_arbiter_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 7;
    localparam logic [ADDR_W-1:0] CHARS = 13'd4800;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_VGA,
        GNT_CPURD,
        GNT_WR
    } grant_e;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_PEND,
        RD_ISSUED,
        RD_WAIT
    } rd_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

    function automatic logic addr_oob(input logic [ADDR_W-1:0] addr);
        return addr >= CHARS;
    endfunction

endpackage

// File: rtl/char_ram_arbiter_wr_fifo.sv
// Synchronous write buffer for CPU character writes; a push into a full
// buffer is only honoured when a pop happens in the same cycle.
module char_wr_fifo
    import char_ram_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk_sys,
    input  logic              clr,
    input  logic              push_i,
    input  logic              pop_i,
    input  fifo_entry_t       wdata_i,
    output fifo_entry_t       rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);

    fifo_entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic                   do_push;
    logic                   do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_sys or posedge clr) begin
        if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; an empty count makes stale entries unreachable.
    always_ff @(posedge clk_sys) begin
        if (do_push) mem_q[wr_ptr_q] <= do_push ? wdata_i : mem_q[wr_ptr_q];
    end

endmodule

// File: rtl/char_ram_arbiter.sv
// Single-port character RAM arbiter: VGA reads win, CPU writes are buffered and
// drained in idle slots. Optional address checking under CHAR_ARB_BOUNDS_EN.
module char_ram_arbiter
    import char_ram_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_sys,
    input  logic              clr,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    input  logic              cpu_we,
    input  logic              cpu_re,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic              cpu_busy,
    output logic              cpu_wfull,
    output logic              wr_overflow,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    grant_e            grant;
    rd_state_e         rd_state_q;
    fifo_entry_t       push_entry;
    fifo_entry_t       head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              wr_in_range;
    logic              rd_oob_in;
    logic              vga_oob_in;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              overflow_d;
    logic              overflow_q;

    logic [ADDR_W-1:0] ram_addr_q;
    logic              ram_we_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic              vga_p1_q, vga_p2_q;
    logic              vga_oob1_q, vga_oob2_q;
    logic              vga_valid_q;
    logic [DATA_W-1:0] vga_data_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_oob_q;
    logic              cpu_busy_q;
    logic              cpu_rvalid_q;
    logic [DATA_W-1:0] cpu_rdata_q;

`ifdef CHAR_ARB_BOUNDS_EN
    assign wr_in_range = !addr_oob(cpu_addr);
    assign rd_oob_in   = addr_oob(cpu_addr);
    assign vga_oob_in  = addr_oob(vga_addr);
`else
    assign wr_in_range = 1'b1;
    assign rd_oob_in   = 1'b0;
    assign vga_oob_in  = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant = GNT_IDLE;
        if (vga_req)
            grant = GNT_VGA;
        else if (rd_state_q == RD_PEND && !rd_oob_q && fifo_empty)
            grant = GNT_CPURD;
        else if (!fifo_empty)
            grant = GNT_WR;
    end

    assign pop        = (grant == GNT_WR);
    assign push_req   = cpu_we && wr_in_range;
    assign push       = push_req && (!fifo_full || pop);
    assign overflow_d = overflow_q | (push_req & fifo_full & ~pop);
    assign push_entry = '{addr: cpu_addr, data: cpu_wdata};

    char_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk_sys (clk_sys),
        .clr     (clr),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_entry),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // RAM port registers plus the two-stage VGA valid pipeline that matches RAM latency.
    always_ff @(posedge clk_sys or posedge clr) begin
        if (clr) begin
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            vga_p1_q    <= 1'b0;
            vga_p2_q    <= 1'b0;
            vga_oob1_q  <= 1'b0;
            vga_oob2_q  <= 1'b0;
            vga_valid_q <= 1'b0;
            vga_data_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            ram_we_q <= 1'b0;
            unique case (grant)
                GNT_VGA:   ram_addr_q <= vga_addr;
                GNT_CPURD: ram_addr_q <= rd_addr_q;
                GNT_WR: begin
                    ram_addr_q  <= head.addr;
                    ram_wdata_q <= head.data;
                    ram_we_q    <= 1'b1;
                end
                default: ;
            endcase
            vga_p1_q    <= (grant == GNT_VGA);
            vga_oob1_q  <= vga_oob_in;
            vga_p2_q    <= vga_p1_q;
            vga_oob2_q  <= vga_oob1_q;
            vga_valid_q <= vga_p2_q;
            if (vga_p2_q) vga_data_q <= vga_oob2_q ? '0 : ram_rdata;
            overflow_q  <= overflow_d;
        end
    end

    // CPU read FSM; ISSUED/WAIT track the RAM address and data cycles of the granted slot.
    always_ff @(posedge clk_sys or posedge clr) begin
        if (clr) begin
            rd_state_q   <= RD_IDLE;
            rd_addr_q    <= '0;
            rd_oob_q     <= 1'b0;
            cpu_busy_q   <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
        end else begin
            cpu_rvalid_q <= 1'b0;
            unique case (rd_state_q)
                RD_IDLE: begin
                    if (cpu_re) begin
                        rd_state_q <= RD_PEND;
                        rd_addr_q  <= cpu_addr;
                        rd_oob_q   <= rd_oob_in;
                        cpu_busy_q <= 1'b1;
                    end
                end
                RD_PEND: begin
                    if (grant == GNT_CPURD || rd_oob_q) rd_state_q <= RD_ISSUED;
                end
                RD_ISSUED: rd_state_q <= RD_WAIT;
                RD_WAIT: begin
                    rd_state_q   <= RD_IDLE;
                    cpu_busy_q   <= 1'b0;
                    cpu_rvalid_q <= 1'b1;
                    cpu_rdata_q  <= rd_oob_q ? '0 : ram_rdata;
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    assign ram_addr    = ram_addr_q;
    assign ram_we      = ram_we_q;
    assign ram_wdata   = ram_wdata_q;
    assign vga_data    = vga_data_q;
    assign vga_valid   = vga_valid_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign cpu_rvalid  = cpu_rvalid_q;
    assign cpu_busy    = cpu_busy_q;
    assign cpu_wfull   = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign wr_overflow = overflow_q;

endmodule

// File: tb/tb_char_ram_arbiter.sv
// Directed bench for char_ram_arbiter with a synchronous character RAM model;
// inputs change and outputs are sampled 1 ns after each rising edge.
module tb_char_ram_arbiter;

    logic        clk_sys = 1'b0;
    logic        clr;
    logic        vga_req;
    logic [12:0] vga_addr;
    logic [6:0]  vga_data;
    logic        vga_valid;
    logic        cpu_we;
    logic        cpu_re;
    logic [12:0] cpu_addr;
    logic [6:0]  cpu_wdata;
    logic [6:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic        cpu_busy;
    logic        cpu_wfull;
    logic        wr_overflow;
    logic [12:0] ram_addr;
    logic        ram_we;
    logic [6:0]  ram_wdata;
    logic [6:0]  ram_rdata;

    logic [6:0]  mem [0:8191];
    int          n_cmp = 0;
    int          n_err = 0;
    int          we_cnt = 0;
    int          rv_cnt = 0;

    always #5 clk_sys = ~clk_sys;

    char_ram_arbiter dut (
        .clk_sys     (clk_sys),
        .clr         (clr),
        .vga_req     (vga_req),
        .vga_addr    (vga_addr),
        .vga_data    (vga_data),
        .vga_valid   (vga_valid),
        .cpu_we      (cpu_we),
        .cpu_re      (cpu_re),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_busy    (cpu_busy),
        .cpu_wfull   (cpu_wfull),
        .wr_overflow (wr_overflow),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    // Single-port RAM, one-cycle synchronous read, read-before-write.
    always @(posedge clk_sys) begin
        ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    always @(negedge clk_sys) begin
        if (ram_we)     we_cnt++;
        if (cpu_rvalid) rv_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rvalid(input int done_steps, output int lat);
        lat = done_steps;
        while (cpu_rvalid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        if (cpu_rvalid !== 1'b1) lat = -1;
    endtask

    function automatic logic [6:0] pre_data(input int i);
        return 7'(32 + 5 * i);
    endfunction

    initial begin
        int lat;
        int we0;
        int rv0;

        clr = 1'b1; vga_req = 1'b0; vga_addr = '0; cpu_we = 1'b0; cpu_re = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
        step(); step();
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_vga_valid", 32'(vga_valid), 0);
        check("rst_cpu_busy", 32'(cpu_busy), 0);
        check("rst_cpu_wfull", 32'(cpu_wfull), 0);
        check("rst_overflow", 32'(wr_overflow), 0);
        clr = 1'b0;
        step();

        // Single write reaches the RAM port two edges after the strobe.
        cpu_we = 1'b1; cpu_addr = 13'd5; cpu_wdata = 7'h41;
        step();
        cpu_we = 1'b0;
        check("wr1_not_yet", 32'(ram_we), 0);
        step();
        check("wr1_ram_we", 32'(ram_we), 1);
        check("wr1_ram_addr", 32'(ram_addr), 5);
        check("wr1_ram_wdata", 32'(ram_wdata), 32'h41);
        step();
        check("wr1_drained", 32'(ram_we), 0);
        check("wr1_mem", 32'(mem[5]), 32'h41);

        // Plain read with a second strobe while busy, which must be ignored.
        rv0 = rv_cnt;
        cpu_re = 1'b1; cpu_addr = 13'd5;
        step();
        cpu_addr = 13'd3;
        check("rd1_busy", 32'(cpu_busy), 1);
        step();
        cpu_re = 1'b0;
        wait_rvalid(2, lat);
        check("rd1_latency", 32'(lat), 4);
        check("rd1_data", 32'(cpu_rdata), 32'h41);
        step();
        check("rd1_pulse_end", 32'(cpu_rvalid), 0);
        check("rd1_busy_clear", 32'(cpu_busy), 0);
        check("rd1_data_held", 32'(cpu_rdata), 32'h41);
        repeat (5) step();
        check("rd1_single_pulse", 32'(rv_cnt - rv0), 1);

        // Preload cells 0..9 through back-to-back CPU writes.
        for (int i = 0; i < 10; i++) begin
            cpu_we = 1'b1; cpu_addr = 13'(i); cpu_wdata = pre_data(i);
            step();
        end
        cpu_we = 1'b0;
        repeat (4) step();
        check("preload_mem9", 32'(mem[9]), 32'(pre_data(9)));

        // Back-to-back VGA reads: valid exactly 3 cycles after each request.
        for (int c = 0; c < 13; c++) begin
            vga_req  = (c < 10);
            vga_addr = 13'(c);
            step();
            check($sformatf("vga_valid_c%0d", c), 32'(vga_valid), 32'((c >= 2 && c <= 11) ? 1 : 0));
            if (c >= 2 && c <= 11)
                check($sformatf("vga_data_c%0d", c), 32'(vga_data), 32'(pre_data(c - 2)));
        end
        vga_req = 1'b0;
        step();

        // Read-after-write: read of 103 completes only after all four writes land.
        we0 = we_cnt;
        for (int i = 0; i < 4; i++) begin
            cpu_we = 1'b1; cpu_addr = 13'(100 + i); cpu_wdata = 7'(8'h50 + i);
            step();
        end
        cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = 13'd103;
        step();
        cpu_re = 1'b0;
        wait_rvalid(1, lat);
        check("raw_latency", 32'(lat), 4);
        check("raw_writes_landed", 32'(we_cnt - we0), 4);
        check("raw_data", 32'(cpu_rdata), 32'h53);
        step();

`ifdef CHAR_ARB_BOUNDS_EN
        we0 = we_cnt;
        cpu_we = 1'b1; cpu_addr = 13'd4800; cpu_wdata = 7'h11;
        step();
        cpu_we = 1'b0;
        repeat (4) step();
        check("oob_write_dropped", 32'(we_cnt - we0), 0);
        check("oob_no_overflow", 32'(wr_overflow), 0);
        cpu_re = 1'b1; cpu_addr = 13'd4900;
        step();
        cpu_re = 1'b0;
        wait_rvalid(1, lat);
        check("oob_read_latency", 32'(lat), 4);
        check("oob_read_data", 32'(cpu_rdata), 0);
`else
        cpu_we = 1'b1; cpu_addr = 13'd4800; cpu_wdata = 7'h11;
        step();
        cpu_we = 1'b0;
        step();
        check("hi_write_we", 32'(ram_we), 1);
        check("hi_write_addr", 32'(ram_addr), 4800);
        step();
        cpu_re = 1'b1; cpu_addr = 13'd4800;
        step();
        cpu_re = 1'b0;
        wait_rvalid(1, lat);
        check("hi_read_latency", 32'(lat), 4);
        check("hi_read_data", 32'(cpu_rdata), 32'h11);
`endif
        step();

        // Overflow: VGA holds every slot, so the fifth write is dropped.
        we0 = we_cnt;
        for (int i = 0; i < 5; i++) begin
            vga_req = 1'b1; vga_addr = 13'd0;
            cpu_we = 1'b1; cpu_addr = 13'(200 + i); cpu_wdata = 7'(8'h60 + i);
            step();
            check($sformatf("ovf_wfull_%0d", i), 32'(cpu_wfull), 32'((i >= 3) ? 1 : 0));
            check($sformatf("ovf_flag_%0d", i), 32'(wr_overflow), 32'((i == 4) ? 1 : 0));
        end
        cpu_we = 1'b0;
        step(); step();
        check("ovf_stalled", 32'(we_cnt - we0), 0);
        vga_req = 1'b0;
        repeat (8) step();
        check("ovf_four_writes", 32'(we_cnt - we0), 4);
        check("ovf_wfull_clear", 32'(cpu_wfull), 0);
        check("ovf_sticky", 32'(wr_overflow), 1);
        check("ovf_mem200", 32'(mem[200]), 32'h60);
        check("ovf_mem203", 32'(mem[203]), 32'h63);

        // Reset with three buffered writes and a pending read.
        for (int i = 0; i < 3; i++) begin
            vga_req = 1'b1; vga_addr = 13'd7;
            cpu_we = 1'b1; cpu_addr = 13'(300 + i); cpu_wdata = 7'(8'h70 + i);
            cpu_re = (i == 2);
            step();
        end
        cpu_we = 1'b0; cpu_re = 1'b0;
        check("mid_busy_before", 32'(cpu_busy), 1);
        check("mid_vvalid_before", 32'(vga_valid), 1);
        #2 clr = 1'b1;
        #1;
        check("mid_vga_valid", 32'(vga_valid), 0);
        check("mid_vga_data", 32'(vga_data), 0);
        check("mid_cpu_rdata", 32'(cpu_rdata), 0);
        check("mid_cpu_busy", 32'(cpu_busy), 0);
        check("mid_cpu_rvalid", 32'(cpu_rvalid), 0);
        check("mid_cpu_wfull", 32'(cpu_wfull), 0);
        check("mid_overflow", 32'(wr_overflow), 0);
        check("mid_ram_addr", 32'(ram_addr), 0);
        check("mid_ram_we", 32'(ram_we), 0);
        check("mid_ram_wdata", 32'(ram_wdata), 0);
        vga_req = 1'b0;
        step();
        clr = 1'b0;
        we0 = we_cnt;
        rv0 = rv_cnt;
        repeat (8) step();
        check("post_rst_no_writes", 32'(we_cnt - we0), 0);
        check("post_rst_no_rvalid", 32'(rv_cnt - rv0), 0);
        check("post_rst_idle", 32'(cpu_busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
